// File: rtl/e161_trace_checker_pkg.sv
// Shared types, output codes and the clean e161 next-state/output table.
// The resync decode is used only when E161_TRACE_RESYNC_EN is defined.
package e161_pkg;

  typedef enum logic [3:0] {
    S1  = 4'd1,
    S2  = 4'd2,
    S3  = 4'd3,
    S4  = 4'd4,
    S5  = 4'd5,
    S6  = 4'd6,
    S7  = 4'd7,
    S8  = 4'd8,
    S9  = 4'd9,
    S10 = 4'd10,
    S11 = 4'd11
  } e161_state_t;

  // yi lives at bit i-1
  function automatic logic [16:0] ybit(input int unsigned i);
    return 17'd1 << (i - 1);
  endfunction

  localparam logic [16:0] CODE_NONE = '0;
  localparam logic [16:0] CODE_A = ybit(7) | ybit(9) | ybit(15);
  localparam logic [16:0] CODE_B = ybit(1) | ybit(8) | ybit(9);
  localparam logic [16:0] CODE_C = ybit(1) | ybit(2) | ybit(3);
  localparam logic [16:0] CODE_D = ybit(10) | ybit(11);
  localparam logic [16:0] CODE_E = ybit(2) | ybit(10);
  localparam logic [16:0] CODE_F = ybit(5);
  localparam logic [16:0] CODE_G = ybit(4);
  localparam logic [16:0] CODE_H = ybit(16);
  localparam logic [16:0] CODE_I = ybit(6);
  localparam logic [16:0] CODE_J = ybit(1) | ybit(9) | ybit(14) | ybit(15);
  localparam logic [16:0] CODE_K = ybit(13);
  localparam logic [16:0] CODE_L = ybit(8) | ybit(9) | ybit(17);
  localparam logic [16:0] CODE_M = ybit(1);
  localparam logic [16:0] CODE_N = ybit(12);

  typedef struct packed {
    logic [16:0] code;
    e161_state_t next;
  } e161_step_t;

  typedef struct packed {
    logic        hit;
    e161_state_t state;
  } e161_resync_t;

  function automatic e161_step_t e161_next(input e161_state_t state, input logic [15:0] x);
    logic [16:1] xv;
    e161_step_t  r;
    xv = x;
    r  = '{CODE_NONE, S1};
    case (state)
      S1: begin
        if (xv[7] && xv[9] && xv[5] && xv[3] && xv[6]) r = '{CODE_A, S2};
        else if (xv[7] && xv[9] && xv[5])              r = '{CODE_B, S3};
        else if (xv[7] && xv[9])                       r = '{CODE_C, S4};
        else if (xv[7])                                r = '{CODE_D, S5};
        else if (xv[1] && xv[15] && xv[5])             r = '{CODE_E, S6};
        else if (xv[1] && xv[15])                      r = '{CODE_B, S3};
        else if (xv[1])                                r = '{CODE_C, S4};
        else if (xv[8])                                r = '{CODE_C, S4};
        else if (xv[2])                                r = '{CODE_F, S7};
        else                                           r = '{CODE_G, S7};
      end
      S2: r = xv[12] ? '{CODE_H, S8} : '{CODE_NONE, S2};
      S3: begin
        if (xv[13]) begin
          if (xv[6] && xv[10] && xv[16]) r = '{CODE_I, S9};
          else if (xv[6] && xv[10])      r = '{CODE_F, S7};
          else if (xv[6])                r = '{CODE_NONE, S3};
          else                           r = '{CODE_NONE, S1};
        end else begin
          if (xv[15] && xv[4] && xv[10]) r = '{CODE_D, S5};
          else if (xv[15] && xv[4])      r = '{CODE_F, S7};
          else if (xv[15])               r = '{CODE_NONE, S3};
          else                           r = '{CODE_NONE, S1};
        end
      end
      S4: r = (xv[12] && !xv[14]) ? '{CODE_F, S7} : '{CODE_G, S7};
      S5: begin
        if (xv[7] && xv[11])      r = '{CODE_C, S4};
        else if (xv[7] && xv[2])  r = '{CODE_F, S7};
        else if (xv[7])           r = '{CODE_G, S7};
        else if (xv[1] && xv[16]) r = '{CODE_J, S2};
        else if (xv[1])           r = '{CODE_K, S9};
        else                      r = '{CODE_NONE, S5};
      end
      S6: begin
        if (xv[1] && xv[16]) r = '{CODE_J, S2};
        else if (xv[1])      r = '{CODE_K, S9};
        else                 r = '{CODE_NONE, S6};
      end
      S7: begin
        if (xv[10]) begin
          if (xv[7] && xv[3] && xv[6]) r = '{CODE_A, S2};
          else if (xv[7])              r = '{CODE_B, S3};
          else if (xv[9])              r = '{CODE_M, S10};
          else if (xv[1])              r = '{CODE_NONE, S1};
          else                         r = '{CODE_B, S3};
        end else begin
          if (xv[11] && xv[5]) r = '{CODE_E, S6};
          else if (xv[11])     r = '{CODE_B, S3};
          else if (xv[9])      r = '{CODE_M, S10};
          else if (xv[1])      r = '{CODE_NONE, S1};
          else                 r = '{CODE_B, S3};
        end
      end
      S8:  r = '{CODE_L, S11};
      S9:  r = '{CODE_H, S8};
      S10: r = xv[1] ? '{CODE_NONE, S1} : '{CODE_B, S3};
      S11: r = xv[4] ? '{CODE_N, S1} : '{CODE_NONE, S11};
      default: r = '{CODE_NONE, S1};
    endcase
    return r;
  endfunction

  // Every nonzero code has exactly one destination state in the table
  function automatic e161_resync_t e161_resync(input logic [16:0] y);
    e161_resync_t r;
    r = '{1'b0, S1};
    case (y)
      CODE_A, CODE_J: r = '{1'b1, S2};
      CODE_B:         r = '{1'b1, S3};
      CODE_C:         r = '{1'b1, S4};
      CODE_D:         r = '{1'b1, S5};
      CODE_E:         r = '{1'b1, S6};
      CODE_F, CODE_G: r = '{1'b1, S7};
      CODE_H:         r = '{1'b1, S8};
      CODE_I, CODE_K: r = '{1'b1, S9};
      CODE_L:         r = '{1'b1, S11};
      CODE_M:         r = '{1'b1, S10};
      CODE_N:         r = '{1'b1, S1};
      default:        r = '{1'b0, S1};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/e161_trace_checker_ref_step.sv
// Combinational evaluation of the clean e161 table for one beat.
import e161_pkg::*;

module e161_ref_step (
  input  logic [3:0]  state,
  input  logic [15:0] x,
  output logic [16:0] code,
  output logic [3:0]  next
);

  e161_step_t r;

  always_comb begin
    r = e161_next(e161_state_t'(state), x);
  end

  assign code = r.code;
  assign next = r.next;

endmodule

// File: rtl/e161_trace_checker.sv
// Golden trace checker for the e161 controller: tracks a clean reference,
// counts divergences and S10/~x1 visits. Define E161_TRACE_RESYNC_EN to
// let the reference resynchronise from observed codes after a mismatch.
import e161_pkg::*;

module e161_trace_checker #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TRIG_THRESH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             smp_valid,
  input  logic [15:0]      smp_x,
  input  logic [16:0]      smp_y,
  output logic [3:0]       mon_state,
  output logic             mon_lost,
  output logic [16:0]      exp_y,
  output logic             err_pulse,
  output logic             err_flag,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] trig_cnt,
  output logic             trig_alarm,
  output logic [3:0]       first_err_state,
  output logic [16:0]      first_err_y
);

  typedef enum logic {TRACK, LOST} mode_t;

  mode_t       mode;
  e161_state_t state;
  logic [16:0] step_code;
  logic [3:0]  step_next;

  e161_ref_step u_step (
    .state (state),
    .x     (smp_x),
    .code  (step_code),
    .next  (step_next)
  );

`ifdef E161_TRACE_RESYNC_EN
  e161_resync_t resync;
  assign resync = e161_resync(smp_y);
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign mon_state  = state;
  assign trig_alarm = (trig_cnt >= CNT_W'(TRIG_THRESH));

  always_ff @(posedge clk) begin
    if (rst) begin
      mode            <= TRACK;
      state           <= S1;
      mon_lost        <= 1'b0;
      exp_y           <= '0;
      err_pulse       <= 1'b0;
      err_flag        <= 1'b0;
      mism_cnt        <= '0;
      beat_cnt        <= '0;
      trig_cnt        <= '0;
      first_err_state <= '0;
      first_err_y     <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (smp_valid) begin
        beat_cnt <= sat_inc(beat_cnt);
        if (mode == TRACK) begin
          exp_y <= step_code;
          if (state == S10 && !smp_x[0]) trig_cnt <= sat_inc(trig_cnt);
          if (smp_y != step_code) begin
            err_pulse <= 1'b1;
            err_flag  <= 1'b1;
            mism_cnt  <= sat_inc(mism_cnt);
            mode      <= LOST;
            mon_lost  <= 1'b1;
            if (!err_flag) begin
              first_err_state <= state;
              first_err_y     <= smp_y;
            end
          end else begin
            state <= e161_state_t'(step_next);
          end
        end else begin
          exp_y <= CODE_NONE;
`ifdef E161_TRACE_RESYNC_EN
          // the resync beat itself is not compared
          if (resync.hit) begin
            state    <= resync.state;
            mode     <= TRACK;
            mon_lost <= 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule
